// File: rtl/dcache_pkg.sv
// Shared types and constants for the write-back data cache (dcache_wb).
package dcache_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WB0     = 4'd1,
        WB1     = 4'd2,
        LD0     = 4'd3,
        LD1     = 4'd4,
        FL_SCAN = 4'd5,
        FL_W0   = 4'd6,
        FL_W1   = 4'd7,
        FL_CNT  = 4'd8,
        DONE    = 4'd9
    } dcache_state_t;

    // Address view for the default 16-set geometry.
    localparam int DEF_IW = 4;
    typedef struct packed {
        logic [28-DEF_IW:0] tag;
        logic [DEF_IW-1:0]  idx;
        logic               blkoff;
        logic [1:0]         byteoff;
    } dcache_addr_t;

    localparam logic [31:0] HITCNT_ADDR = 32'h0000_3100;

endpackage

// File: rtl/dcache_frame_array.sv
// Per-set storage for the data cache: valid, dirty, tag and a 2-word block.
module dcache_frame_array #(
    parameter int SETS = 16,
    parameter int IW   = $clog2(SETS),
    parameter int TW   = 29 - IW
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [IW-1:0]     rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TW-1:0]     rd_tag,
    output logic [1:0][31:0]  rd_data,
    input  logic [IW-1:0]     wr_idx,
    input  logic [1:0]        wr_we,
    input  logic [31:0]       wr_word,
    input  logic              wr_tag_en,
    input  logic [TW-1:0]     wr_tag,
    input  logic              set_dirty,
    input  logic              clr_dirty
);
    import dcache_pkg::*;

    logic [SETS-1:0]    valid;
    logic [SETS-1:0]    dirty;
    logic [TW-1:0]      tags [SETS];
    logic [1:0][31:0]   data [SETS];

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (wr_tag_en)
                valid[wr_idx] <= 1'b1;
            if (set_dirty)
                dirty[wr_idx] <= 1'b1;
            else if (clr_dirty)
                dirty[wr_idx] <= 1'b0;
        end
    end

    // Tag and data carry no reset; valid gates their use.
    always_ff @(posedge CLK) begin
        if (wr_tag_en)
            tags[wr_idx] <= wr_tag;
        for (int w = 0; w < 2; w++)
            if (wr_we[w])
                data[wr_idx][w] <= wr_word;
    end

endmodule

// File: rtl/dcache_wb.sv
// Write-back direct-mapped data cache with 2-word blocks and halt flush.
// Optional hit/miss counter written out after flush: define DCACHE_HITCNT_EN.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int SETS        = 16,
    parameter int MEM_LAT_MAX = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 29 - IW;

    dcache_state_t      state;
    logic [IW-1:0]      fl_idx, miss_idx, rd_idx, req_idx;
    logic [TW-1:0]      miss_tag, req_tag, rd_tag, wr_tag;
    logic               rd_valid, rd_dirty, req, wsel, hit, miss, fl_last;
    logic [1:0][31:0]   rd_data;
    logic [1:0]         wr_we;
    logic [31:0]        wr_word;
    logic               wr_tag_en, set_dirty, clr_dirty;
    logic               unused_byteoff;

    assign req            = dmemREN | dmemWEN;
    assign req_idx        = dmemaddr[IW+2:3];
    assign req_tag        = dmemaddr[31:IW+3];
    assign wsel           = dmemaddr[2];
    assign unused_byteoff = ^dmemaddr[1:0];
    assign fl_last        = (fl_idx == IW'(SETS - 1));

    assign hit      = (state == IDLE) && req && rd_valid && (rd_tag == req_tag);
    assign miss     = (state == IDLE) && req && !hit;
    assign dhit     = hit;
    assign dmemload = (hit && !dmemWEN) ? rd_data[wsel] : 32'h0;
    assign flushed  = (state == DONE);

`ifdef DCACHE_HITCNT_EN
    localparam dcache_state_t SCAN_END = FL_CNT;
    logic [31:0] hit_cnt;

    always_ff @(posedge CLK) begin
        if (!nRST)
            hit_cnt <= '0;
        else if (hit)
            hit_cnt <= hit_cnt + 32'd1;
        else if (miss)
            hit_cnt <= hit_cnt - 32'd1;
    end
`else
    localparam dcache_state_t SCAN_END = DONE;
`endif

    always_comb begin
        rd_idx = req_idx;
        case (state)
            WB0, WB1, LD0, LD1:    rd_idx = miss_idx;
            FL_SCAN, FL_W0, FL_W1: rd_idx = fl_idx;
            default: ;
        endcase
    end

    always_comb begin
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = 32'h0;
        dstore    = 32'h0;
        wr_we     = 2'b00;
        wr_word   = dload;
        wr_tag_en = 1'b0;
        wr_tag    = miss_tag;
        set_dirty = 1'b0;
        clr_dirty = 1'b0;
        case (state)
            IDLE: if (hit && dmemWEN) begin
                wr_we     = wsel ? 2'b10 : 2'b01;
                wr_word   = dmemstore;
                set_dirty = 1'b1;
            end
            WB0, WB1: begin
                dWEN   = 1'b1;
                daddr  = {rd_tag, miss_idx, state == WB1, 2'b00};
                dstore = rd_data[state == WB1];
            end
            LD0, LD1: begin
                dREN  = 1'b1;
                daddr = {miss_tag, miss_idx, state == LD1, 2'b00};
                if (!dwait) begin
                    wr_we     = (state == LD1) ? 2'b10 : 2'b01;
                    wr_tag_en = (state == LD1);
                    clr_dirty = (state == LD1);
                end
            end
            FL_W0, FL_W1: begin
                dWEN      = 1'b1;
                daddr     = {rd_tag, fl_idx, state == FL_W1, 2'b00};
                dstore    = rd_data[state == FL_W1];
                clr_dirty = (state == FL_W1) && !dwait;
            end
`ifdef DCACHE_HITCNT_EN
            FL_CNT: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = hit_cnt;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            fl_idx   <= '0;
            miss_idx <= '0;
            miss_tag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        miss_idx <= req_idx;
                        miss_tag <= req_tag;
                        state    <= rd_dirty ? WB0 : LD0;
                    end else if (halt && !req) begin
                        fl_idx <= '0;
                        state  <= FL_SCAN;
                    end
                end
                WB0:     if (!dwait) state <= WB1;
                WB1:     if (!dwait) state <= LD0;
                LD0:     if (!dwait) state <= LD1;
                LD1:     if (!dwait) state <= IDLE;
                FL_SCAN: begin
                    if (rd_valid && rd_dirty)
                        state <= FL_W0;
                    else if (fl_last)
                        state <= SCAN_END;
                    else
                        fl_idx <= fl_idx + 1'b1;
                end
                FL_W0:   if (!dwait) state <= FL_W1;
                FL_W1: begin
                    if (!dwait) begin
                        state <= fl_last ? SCAN_END : FL_SCAN;
                        if (!fl_last)
                            fl_idx <= fl_idx + 1'b1;
                    end
                end
                FL_CNT:  if (!dwait) state <= DONE;
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    dcache_frame_array #(.SETS(SETS)) u_frames (
        .CLK       (CLK),
        .nRST      (nRST),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_idx    (rd_idx),
        .wr_we     (wr_we),
        .wr_word   (wr_word),
        .wr_tag_en (wr_tag_en),
        .wr_tag    (wr_tag),
        .set_dirty (set_dirty),
        .clr_dirty (clr_dirty)
    );

    generate
        if (MEM_LAT_MAX != 0) begin : g_lat_chk
            logic [31:0] wait_cnt;
            always_ff @(posedge CLK) begin
                if (!nRST || !((dREN || dWEN) && dwait))
                    wait_cnt <= '0;
                else
                    wait_cnt <= wait_cnt + 32'd1;
            end
            a_mem_lat: assert property (@(posedge CLK) disable iff (!nRST)
                wait_cnt <= 32'(MEM_LAT_MAX));
        end
    endgenerate

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Write-back, direct-mapped data cache between the pipelined datapath MEM stage and the memory controller.
- Serves MEM-stage dmemREN/dmemWEN requests, which carry the EX/MEM ALU result as the address.
- Returns dhit and dmemload combinationally on a hit; these feed the pipeline stall and forwarding logic.
- Fills and evicts 2-word blocks over a single-word request/dwait memory port; writes back all dirty blocks when the datapath halts.

Parameters:
- SETS, 16, number of cache lines (power of two, ≥2); index width IW = log2(SETS).
- MEM_LAT_MAX, 0, if nonzero a simulation assertion fires when dwait stays high longer than MEM_LAT_MAX cycles; 0 disables the check.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous active-low reset.
- dmemREN  in  1  datapath load request.
- dmemWEN  in  1  datapath store request.
- dmemaddr  in  32  byte address, word aligned.
- dmemstore  in  32  store data.
- halt  in  1  datapath halted; request flush.
- dhit  out  1  request served this cycle.
- dmemload  out  32  load data, valid when dhit.
- flushed  out  1  flush complete, sticky.
- dREN  out  1  memory read.
- dWEN  out  1  memory write.
- daddr  out  32  memory address.
- dstore  out  32  memory write data.
- dwait  in  1  memory busy; the access completes on the first cycle dwait=0.
- dload  in  32  memory read data.

Behaviour:
- Reset is synchronous and active-low on CLK. Reset clears all valid and dirty bits, FSM=IDLE, flushed=0, and the hit counter. In the cycle after reset: dREN=dWEN=0, dhit=0, dmemload=0, daddr=0, dstore=0.
- Address split: [1:0] byte (ignored), [2] word-in-block, [IW+2:3] index, [31:IW+3] tag.
- Request: dmemWEN=1 is a write; dmemREN=1 alone is a read. If both are high, write has priority.
- IDLE hit (valid && tag match):
  - dhit=1 in the same cycle.
  - Read: dmemload = selected word.
  - Write: the word is updated and dirty set at the next edge.
- dmemload=0 whenever dhit=0.
- IDLE miss: go to WB0 if the line is dirty, else LD0. dhit=0 for the whole miss.
- WB0/WB1:
  - dWEN=1, daddr = {victim tag, index, w, 2'b00} with w=0 then 1, dstore = that word.
  - Advance on dwait=0; WB1 goes to LD0.
- LD0/LD1:
  - dREN=1, daddr = {request tag, index, w, 2'b00}.
  - On dwait=0, capture dload into word w.
  - LD1 completion writes the tag, sets valid, clears dirty, returns to IDLE.
  - The still-held request hits on the following cycle, so the minimum clean-miss penalty is 3 cycles with dwait=0.
- Memory-port rules:
  - dREN and dWEN are never both high.
  - daddr and dstore are held stable while dwait=1.
  - If the request drops mid-miss, the fill still completes.
- Flush: halt=1 observed in IDLE with no request pending → FL_SCAN.
  - FL_SCAN walks index 0..SETS-1 with a counter.
  - A dirty line goes through FL_W0 and FL_W1 (same addressing as WB) and its dirty bit is cleared.
  - A clean or invalid line takes 1 cycle.
  - After the index wraps from SETS-1: go to FL_CNT if enabled, else DONE.
- DONE: flushed=1, dhit=0, no memory traffic. Exit only by reset.
- A halt arriving during a miss is honoured after return to IDLE.
- A reset mid-miss or mid-flush aborts immediately; the memory-side access is dropped.

Optional Feature:
- Macro: DCACHE_HITCNT_EN.
- Defined:
  - 32-bit counter increments once per IDLE hit cycle and decrements once per miss (at miss entry), wrapping modulo 2^32.
  - FL_CNT performs dWEN=1, daddr=32'h0000_3100, dstore=counter, then goes to DONE.
- Undefined: no counter, FL_CNT absent, FL_SCAN goes directly to DONE.

Decomposition:
- Package dcache_pkg:
  - dcache_state_t enum (IDLE, WB0, WB1, LD0, LD1, FL_SCAN, FL_W0, FL_W1, FL_CNT, DONE).
  - dcache_addr_t packed struct (tag, idx, blkoff, byteoff).
  - HITCNT_ADDR = 32'h3100.
- Sub-module dcache_frame_array: SETS-entry storage holding valid, dirty, tag and data[2].
  - One read port (index) and one write port (index, per-word write enables, set/clear dirty).
  - Synchronous reset of valid and dirty only.
- The FSM and address muxing stay in dcache_wb.

Test Plan:
1. Cold load of 0x40; memory holds 0x40=0xAAAA0001, 0x44=0xAAAA0002; dwait=0 → dREN at 0x40 then 0x44, no dWEN; 3rd cycle dhit=1, dmemload=0xAAAA0001; next load of 0x44 hits in 0 wait cycles with 0xAAAA0002.
2. Store 0x12345678 to 0x40 (hit), then load 0xC0 (same index, SETS=16) → dWEN 0x40=0x12345678, dWEN 0x44=0xAAAA0002, then dREN 0xC0, 0xC4, then dhit.
3. dwait=1 for 5 cycles during LD0 → daddr held at 0xC0, dREN held, dhit=0 throughout; proceeds on the 6th cycle.
4. Lines 3 and 9 dirty, halt=1 → exactly 4 dWEN at the line addresses in ascending index order; flushed=1 after the scan (plus 1 write to 0x3100 with DCACHE_HITCNT_EN); clean lines produce no traffic.
5. nRST=0 asserted during WB1 → next cycle dREN=dWEN=0; a subsequent load of the previously cached address misses.
6. With DCACHE_HITCNT_EN: 7 hits, 2 misses, halt → final write to 0x3100 with dstore=5.
